// File: rtl/iir_axi4lite_regs.sv
// AXI4-lite register front end for the IIR filter core: START/DONE control,
// 32-word input sample buffer, 32-word output result buffer.
// Optional build macro: IIR_REGS_ERR_RESP_EN -- when defined, illegal accesses
// answer SLVERR; otherwise every response is OKAY (side effects identical).
module iir_axi4lite_regs #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [AW-1:0]     aw_addr_i,
  input  logic              aw_valid_i,
  output logic              aw_ready_o,
  input  logic [DW-1:0]     w_data_i,
  input  logic [DW/8-1:0]   w_strb_i,
  input  logic              w_valid_i,
  output logic              w_ready_o,
  output logic [1:0]        b_resp_o,
  output logic              b_valid_o,
  input  logic              b_ready_i,
  input  logic [AW-1:0]     ar_addr_i,
  input  logic              ar_valid_i,
  output logic              ar_ready_o,
  output logic [DW-1:0]     r_data_o,
  output logic [1:0]        r_resp_o,
  output logic              r_valid_o,
  input  logic              r_ready_i,
  output logic              core_start_o,
  input  logic [4:0]        core_in_idx_i,
  output logic [31:0]       core_in_data_o,
  input  logic              core_out_we_i,
  input  logic [4:0]        core_out_idx_i,
  input  logic [31:0]       core_out_data_i,
  input  logic              core_done_i
);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
`ifdef IIR_REGS_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic                 aw_held, w_held;
  logic [9:2]           aw_word_q;
  logic [DW-1:0]        w_data_q;
  logic [DW/8-1:0]      w_strb_q;
  logic                 start_q, done_q, busy_q, start_pend;
  logic [31:0][DW-1:0]  in_buf;
  logic [31:0][31:0]    out_buf;

  // Only the word offset within the 1 KiB window is decoded.
  logic unused_addr;
  assign unused_addr = ^{aw_addr_i[AW-1:10], aw_addr_i[1:0], ar_addr_i[AW-1:10], ar_addr_i[1:0]};

  assign aw_ready_o = !aw_held;
  assign w_ready_o  = !w_held;
  assign ar_ready_o = !r_valid_o;

  // Write decode on the held address/data
  logic wr_exec, wr_is_start, wr_is_in, wr_err, in_we, start_edge, b_hs;
  always_comb begin
    wr_exec     = aw_held && w_held && !b_valid_o;
    wr_is_start = (aw_word_q == 8'h00);
    wr_is_in    = (aw_word_q[9:7] == 3'b010);
    wr_err      = !(wr_is_start || (wr_is_in && !busy_q));
    in_we       = wr_exec && wr_is_in && !busy_q;
    start_edge  = wr_exec && wr_is_start && w_strb_q[0] && w_data_q[0] && !start_q;
    b_hs        = b_valid_o && b_ready_i;
  end

  // Read decode; a same-cycle core write to the addressed OUT word is forwarded
  logic        ar_hs, rd_err;
  logic [31:0] rd_data;
  always_comb begin
    ar_hs   = ar_valid_i && ar_ready_o;
    rd_err  = 1'b0;
    rd_data = '0;
    if (ar_addr_i[9:2] == 8'h00)            rd_data = {31'b0, start_q};
    else if (ar_addr_i[9:2] == 8'h02)       rd_data = {31'b0, done_q};
    else if (ar_addr_i[9:7] == 3'b010)      rd_data = in_buf[ar_addr_i[6:2]];
    else if (ar_addr_i[9:7] == 3'b100) begin
      if (core_out_we_i && core_out_idx_i == ar_addr_i[6:2]) rd_data = core_out_data_i;
      else                                                   rd_data = out_buf[ar_addr_i[6:2]];
    end else                                rd_err = 1'b1;
  end

  // One-deep AW/W holding registers, released when the write executes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_held <= 1'b0; aw_word_q <= '0;
      w_held  <= 1'b0; w_data_q  <= '0; w_strb_q <= '0;
    end else begin
      if (aw_valid_i && aw_ready_o) begin
        aw_held <= 1'b1; aw_word_q <= aw_addr_i[9:2];
      end else if (wr_exec) aw_held <= 1'b0;
      if (w_valid_i && w_ready_o) begin
        w_held <= 1'b1; w_data_q <= w_data_i; w_strb_q <= w_strb_i;
      end else if (wr_exec) w_held <= 1'b0;
    end
  end

  // Write response channel, held until accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      b_valid_o <= 1'b0; b_resp_o <= OKAY;
    end else if (wr_exec) begin
      b_valid_o <= 1'b1; b_resp_o <= (wr_err && ERR_EN) ? SLVERR : OKAY;
    end else if (b_hs) b_valid_o <= 1'b0;
  end

  // Control state: start edge beats a coincident done; pulse waits for the B handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_q <= 1'b0; done_q <= 1'b0; busy_q <= 1'b0;
      start_pend <= 1'b0; core_start_o <= 1'b0;
    end else begin
      if (wr_exec && wr_is_start && w_strb_q[0]) start_q <= w_data_q[0];
      if (start_edge) begin
        done_q <= 1'b0; busy_q <= 1'b1;
      end else if (core_done_i) begin
        done_q <= 1'b1; busy_q <= 1'b0;
      end
      if (start_edge)  start_pend <= 1'b1;
      else if (b_hs)   start_pend <= 1'b0;
      core_start_o <= b_hs && start_pend;
    end
  end

  // Input buffer: byte-strobed bus writes, registered core read port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_buf <= '0; core_in_data_o <= '0;
    end else begin
      if (in_we)
        for (int b = 0; b < DW/8; b++)
          if (w_strb_q[b]) in_buf[aw_word_q[6:2]][b*8 +: 8] <= w_data_q[b*8 +: 8];
      core_in_data_o <= in_buf[core_in_idx_i];
    end
  end

  // Output buffer: written only by the core
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            out_buf <= '0;
    else if (core_out_we_i) out_buf[core_out_idx_i] <= core_out_data_i;
  end

  // Read data channel, held until accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0; r_data_o <= '0; r_resp_o <= OKAY;
    end else if (ar_hs) begin
      r_valid_o <= 1'b1; r_data_o <= rd_data;
      r_resp_o  <= (rd_err && ERR_EN) ? SLVERR : OKAY;
    end else if (r_valid_o && r_ready_i) r_valid_o <= 1'b0;
  end

endmodule

// File: tb/tb_iir_axi4lite_regs.sv
// Self-checking bench for iir_axi4lite_regs: directed bus/core stimulus checked
// against a register-level model plus literal expectations.
module tb_iir_axi4lite_regs;

  localparam logic [1:0] OK = 2'b00;
`ifdef IIR_REGS_ERR_RESP_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic        clk, rst_ni;
  logic [31:0] aw_addr_i, w_data_i, ar_addr_i, r_data_o, core_in_data_o, core_out_data_i;
  logic [3:0]  w_strb_i;
  logic        aw_valid_i, aw_ready_o, w_valid_i, w_ready_o, b_valid_o, b_ready_i;
  logic        ar_valid_i, ar_ready_o, r_valid_o, r_ready_i;
  logic [1:0]  b_resp_o, r_resp_o;
  logic        core_start_o, core_out_we_i, core_done_i;
  logic [4:0]  core_in_idx_i, core_out_idx_i;

  iir_axi4lite_regs #(.AW(32), .DW(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .aw_addr_i(aw_addr_i), .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o),
    .w_data_i(w_data_i), .w_strb_i(w_strb_i), .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
    .b_resp_o(b_resp_o), .b_valid_o(b_valid_o), .b_ready_i(b_ready_i),
    .ar_addr_i(ar_addr_i), .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o),
    .r_data_o(r_data_o), .r_resp_o(r_resp_o), .r_valid_o(r_valid_o), .r_ready_i(r_ready_i),
    .core_start_o(core_start_o), .core_in_idx_i(core_in_idx_i), .core_in_data_o(core_in_data_o),
    .core_out_we_i(core_out_we_i), .core_out_idx_i(core_out_idx_i),
    .core_out_data_i(core_out_data_i), .core_done_i(core_done_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int pulse_cnt = 0, exp_pulses = 0;

  // Register-level model
  logic [31:0] m_in  [32];
  logic [31:0] m_out [32];
  logic        m_start, m_done, m_busy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", nm, act, exp);
    end
  endtask

  task automatic fail_timeout(input string nm);
    checks++; failures++;
    $display("FAIL %s timed out waiting for DUT", nm);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin m_in[i] = '0; m_out[i] = '0; end
    m_start = 0; m_done = 0; m_busy = 0;
  endtask

  task automatic model_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] r);
    d = '0; r = OK;
    if (a <= 10'h003)                          d = {31'b0, m_start};
    else if (a >= 10'h008 && a <= 10'h00B)     d = {31'b0, m_done};
    else if (a >= 10'h100 && a <= 10'h17F)     d = m_in[(a - 10'h100) / 4];
    else if (a >= 10'h200 && a <= 10'h27F)     d = m_out[(a - 10'h200) / 4];
    else                                       r = ERR;
  endtask

  task automatic model_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] r);
    r = ERR;
    if (a <= 10'h003) begin
      r = OK;
      if (s[0]) begin
        if (d[0] && !m_start) begin m_done = 0; m_busy = 1; exp_pulses++; end
        m_start = d[0];
      end
    end else if (a >= 10'h100 && a <= 10'h17F && !m_busy) begin
      r = OK;
      for (int b = 0; b < 4; b++)
        if (s[b]) m_in[(a - 10'h100) / 4][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  // Every cycle: core_in_data_o must equal the model's IN word addressed one cycle earlier
  initial begin
    logic [31:0] exp_q;
    bit          exp_ok;
    core_in_idx_i = 5'd0;
    exp_ok = 0; exp_q = '0;
    forever begin
      @(posedge clk);
      exp_ok = rst_ni;
      exp_q  = m_in[core_in_idx_i];
      @(negedge clk);
      if (exp_ok && rst_ni) chk("core_in_data", core_in_data_o, exp_q);
      if (core_start_o) pulse_cnt++;
      core_in_idx_i = core_in_idx_i + 5'd7;
    end
  end

  // Tasks start and end just after a falling edge
  task automatic axi_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] er;
    bit awd, wd;
    int n;
    aw_addr_i = {22'b0, a}; aw_valid_i = 1; w_data_i = d; w_strb_i = s; w_valid_i = 1;
    b_ready_i = 1; awd = 0; wd = 0; n = 0;
    while (!(awd && wd) && n < 20) begin
      if (aw_valid_i && aw_ready_o) awd = 1;
      if (w_valid_i && w_ready_o)   wd  = 1;
      @(negedge clk); n++;
      if (awd) aw_valid_i = 0;
      if (wd)  w_valid_i  = 0;
    end
    aw_valid_i = 0; w_valid_i = 0;
    n = 0;
    while (!b_valid_o && n < 20) begin @(negedge clk); n++; end
    if (!b_valid_o) begin fail_timeout("wr_b"); return; end
    model_write(a, d, s, er);
    chk("wr_resp", {30'b0, b_resp_o}, {30'b0, er});
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [9:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    d = '0; r = OK;
    ar_addr_i = {22'b0, a}; ar_valid_i = 1; r_ready_i = 1; n = 0;
    while (!ar_ready_o && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    ar_valid_i = 0;
    n = 0;
    while (!r_valid_o && n < 20) begin @(negedge clk); n++; end
    if (!r_valid_o) begin fail_timeout("rd_r"); return; end
    d = r_data_o; r = r_resp_o;
    @(negedge clk);
  endtask

  task automatic check_read(input logic [9:0] a, input string nm, output logic [31:0] d);
    logic [31:0] ed; logic [1:0] r, er;
    axi_read(a, d, r);
    model_read(a, ed, er);
    chk(nm, d, ed);
    chk({nm, "_resp"}, {30'b0, r}, {30'b0, er});
  endtask

  task automatic core_write(input logic [4:0] i, input logic [31:0] d);
    core_out_we_i = 1; core_out_idx_i = i; core_out_data_i = d;
    @(negedge clk);
    core_out_we_i = 0;
    m_out[i] = d;
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_awready"}, {31'b0, aw_ready_o}, 1);
    chk({nm, "_wready"},  {31'b0, w_ready_o}, 1);
    chk({nm, "_arready"}, {31'b0, ar_ready_o}, 1);
    chk({nm, "_bvalid"},  {31'b0, b_valid_o}, 0);
    chk({nm, "_rvalid"},  {31'b0, r_valid_o}, 0);
    chk({nm, "_start"},   {31'b0, core_start_o}, 0);
  endtask

  initial begin
    logic [31:0] d, saved;
    logic [1:0]  r, er;
    rst_ni = 0;
    aw_addr_i = '0; aw_valid_i = 0; w_data_i = '0; w_strb_i = '0; w_valid_i = 0; b_ready_i = 1;
    ar_addr_i = '0; ar_valid_i = 0; r_ready_i = 1;
    core_out_we_i = 0; core_out_idx_i = '0; core_out_data_i = '0; core_done_i = 0;
    model_clear();
    repeat (3) @(negedge clk);
    reset_checks("rst");
    chk("rst_rdata", r_data_o, 0);
    chk("rst_core_in", core_in_data_o, 0);
    rst_ni = 1;
    @(negedge clk);

    // Reset readback
    check_read(10'h008, "rd_done0", d);  chk("lit_done0", d, 0);
    check_read(10'h000, "rd_start0", d);
    check_read(10'h114, "rd_in5_0", d);
    reset_checks("idle");

    // Fill IN buffer, strobe writes
    for (int i = 0; i < 32; i++) axi_write(10'h100 + 10'(i*4), 32'(i*4), 4'hF);
    check_read(10'h17C, "rd_in31", d);   chk("lit_in31", d, 32'h7C);
    axi_write(10'h10C, 32'hFFFF_FFFF, 4'b0001);
    check_read(10'h10C, "rd_in3", d);    chk("lit_in3", d, 32'hFF);
    axi_write(10'h110, 32'hAABB_CCDD, 4'b1010);
    check_read(10'h110, "rd_in4", d);    chk("lit_in4", d, 32'hAA00_CC10);
    repeat (4) @(negedge clk);

    // Start handshake
    axi_write(10'h000, 32'h1, 4'h1);
    chk("start_pulse_hi", {31'b0, core_start_o}, 1);
    @(negedge clk);
    chk("start_pulse_lo", {31'b0, core_start_o}, 0);
    axi_write(10'h000, 32'h1, 4'h1);       // already 1: no pulse
    repeat (2) @(negedge clk);
    chk("pulse_cnt_1", pulse_cnt, 1);
    axi_write(10'h000, 32'h0, 4'h1);
    check_read(10'h008, "rd_done_busy", d); chk("lit_done_busy", d, 0);

    // Illegal accesses while busy
    axi_write(10'h100, 32'h1234, 4'hF);
    chk("lit_busy_resp", {30'b0, b_resp_o}, {30'b0, ERR});
    check_read(10'h100, "rd_in0_kept", d); chk("lit_in0_kept", d, 0);
    axi_read(10'h300, d, r);
    chk("lit_unmap_data", d, 0);
    chk("lit_unmap_resp", {30'b0, r}, {30'b0, ERR});
    axi_write(10'h008, 32'h1, 4'hF);
    axi_write(10'h204, 32'h1, 4'hF);

    // Core results, same-cycle OUT forwarding, completion
    core_write(5'd0, 32'h0000_000A);
    core_write(5'd31, 32'hFFFF_FFED);
    ar_addr_i = 32'h204; ar_valid_i = 1; r_ready_i = 1;
    core_out_we_i = 1; core_out_idx_i = 5'd1; core_out_data_i = 32'h55AA;
    @(negedge clk);
    ar_valid_i = 0; core_out_we_i = 0; m_out[1] = 32'h55AA;
    chk("fwd_rvalid", {31'b0, r_valid_o}, 1);
    chk("lit_fwd_data", r_data_o, 32'h55AA);
    @(negedge clk);
    core_done_i = 1; @(negedge clk); core_done_i = 0;
    m_done = 1; m_busy = 0;
    check_read(10'h008, "rd_done1", d);  chk("lit_done1", d, 1);
    check_read(10'h200, "rd_out0", d);   chk("lit_out0", d, 32'hA);
    check_read(10'h27C, "rd_out31", d);  chk("lit_out31", d, 32'hFFFF_FFED);
    check_read(10'h204, "rd_out1", d);

    // W two cycles ahead of AW, B held off for 5 cycles, second write queued behind it
    b_ready_i = 0;
    w_data_i = 32'h77; w_strb_i = 4'hF; w_valid_i = 1;
    @(negedge clk); w_valid_i = 0;
    chk("stall_wready0", {31'b0, w_ready_o}, 0);
    @(negedge clk); aw_addr_i = 32'h11C; aw_valid_i = 1;
    @(negedge clk); aw_valid_i = 0;
    chk("stall_bvalid_early", {31'b0, b_valid_o}, 0);
    @(negedge clk);
    chk("stall_bvalid_rise", {31'b0, b_valid_o}, 1);
    model_write(10'h11C, 32'h77, 4'hF, er);
    chk("stall_resp", {30'b0, b_resp_o}, {30'b0, er});
    saved = {30'b0, b_resp_o};
    aw_addr_i = 32'h120; w_data_i = 32'h88; aw_valid_i = 1; w_valid_i = 1;
    @(negedge clk); aw_valid_i = 0; w_valid_i = 0;
    for (int k = 0; k < 4; k++) begin
      chk("stall_awready", {31'b0, aw_ready_o}, 0);
      chk("stall_wready",  {31'b0, w_ready_o}, 0);
      chk("stall_bvalid",  {31'b0, b_valid_o}, 1);
      chk("stall_bresp",   {30'b0, b_resp_o}, saved);
      @(negedge clk);
    end
    b_ready_i = 1;
    @(negedge clk);
    chk("stall_b_done", {31'b0, b_valid_o}, 0);
    chk("stall_awready_q", {31'b0, aw_ready_o}, 0);
    @(negedge clk);
    chk("stall_b2", {31'b0, b_valid_o}, 1);
    model_write(10'h120, 32'h88, 4'hF, er);
    chk("stall_resp2", {30'b0, b_resp_o}, {30'b0, er});
    @(negedge clk);
    check_read(10'h11C, "rd_in7", d);    chk("lit_in7", d, 32'h77);
    check_read(10'h120, "rd_in8", d);    chk("lit_in8", d, 32'h88);

    // Start edge and core_done_i in the same cycle: start wins
    aw_addr_i = 32'h0; w_data_i = 32'h1; w_strb_i = 4'h1; aw_valid_i = 1; w_valid_i = 1; b_ready_i = 1;
    @(negedge clk); aw_valid_i = 0; w_valid_i = 0; core_done_i = 1;
    @(negedge clk); core_done_i = 0;
    chk("col_bvalid", {31'b0, b_valid_o}, 1);
    model_write(10'h000, 32'h1, 4'h1, er);
    chk("col_resp", {30'b0, b_resp_o}, {30'b0, er});
    @(negedge clk);
    chk("col_pulse", {31'b0, core_start_o}, 1);
    check_read(10'h008, "rd_done_col", d); chk("lit_done_col", d, 0);
    axi_write(10'h108, 32'h1234, 4'hF);    // busy: dropped
    chk("lit_col_busy", {30'b0, b_resp_o}, {30'b0, ERR});
    check_read(10'h108, "rd_in2_kept", d); chk("lit_in2_kept", d, 32'h8);
    chk("pulse_cnt_2", pulse_cnt, exp_pulses);

    // Reset in the middle of a read
    ar_addr_i = 32'h008; ar_valid_i = 1; r_ready_i = 0;
    @(negedge clk); ar_valid_i = 0;
    chk("mid_rvalid", {31'b0, r_valid_o}, 1);
    @(negedge clk);
    rst_ni = 0; #1;
    reset_checks("mid_rst");
    model_clear();
    repeat (2) @(negedge clk);
    rst_ni = 1; r_ready_i = 1;
    @(negedge clk);
    check_read(10'h008, "rd_done_rst", d); chk("lit_done_rst", d, 0);
    check_read(10'h17C, "rd_in31_rst", d);

    // Reset between start execution and B handshake: pulse is discarded
    saved = pulse_cnt;
    b_ready_i = 0;
    aw_addr_i = 32'h0; w_data_i = 32'h1; w_strb_i = 4'h1; aw_valid_i = 1; w_valid_i = 1;
    @(negedge clk); aw_valid_i = 0; w_valid_i = 0;
    @(negedge clk);
    chk("pend_bvalid", {31'b0, b_valid_o}, 1);
    rst_ni = 0; model_clear();
    repeat (2) @(negedge clk);
    rst_ni = 1; b_ready_i = 1;
    repeat (3) @(negedge clk);
    chk("no_pulse_after_rst", pulse_cnt, saved);
    check_read(10'h000, "rd_start_rst", d); chk("lit_start_rst", d, 0);
    chk("pulse_total", pulse_cnt, exp_pulses);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/iir_axi4lite_regs.md
# iir_axi4lite_regs

AXI4-lite slave register front end for the IIR filter core. It holds the 32-entry input sample buffer and the 32-entry output result buffer, generates the core start pulse, and latches completion status. It sits directly upstream of the IIR datapath and is the block the bus driver's `iir_setInData`, `iir_getOutData`, `IIR_START` and `IIR_DONE` accesses land on.

## Interface
- AW, 32, AXI address width; decode uses bits [9:0] only
- DW, 32, AXI data width; fixed at 32
- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- aw_addr_i / aw_valid_i / aw_ready_o  in/in/out  AW/1/1  write address channel
- w_data_i / w_strb_i / w_valid_i / w_ready_o  in/in/in/out  DW/DW/8/1/1  write data channel
- b_resp_o / b_valid_o / b_ready_i  out/out/in  2/1/1  write response channel
- ar_addr_i / ar_valid_i / ar_ready_o  in/in/out  AW/1/1  read address channel
- r_data_o / r_resp_o / r_valid_o / r_ready_i  out/out/out/in  DW/2/1/1  read data channel
- core_start_o  out  1  one-cycle start pulse to the IIR core
- core_in_idx_i  in  5  input-buffer read index from the core
- core_in_data_o  out  32  `in_buf[core_in_idx_i]`, registered, valid 1 cycle after the index
- core_out_we_i / core_out_idx_i / core_out_data_i  in  1/5/32  result write port into the output buffer
- core_done_i  in  1  one-cycle completion pulse from the core

## Operation
- Register map (byte offsets, bits [9:0]):
  - 0x000 START, RW, bit0
  - 0x008 DONE, RO, bit0
  - 0x100–0x17C IN[0..31], RW
  - 0x200–0x27C OUT[0..31], RO
  - all other offsets unmapped, read as 0
- Start: a rising edge of START.bit0 (stored 0, written 1) produces `core_start_o`=1 for exactly one cycle, starting the cycle after the B handshake completes. It also clears DONE and sets internal `busy`. Writing 1 while START is already 1 produces no pulse.
- DONE: sticky. Set on `core_done_i`, which also clears `busy`.
- If a start edge and `core_done_i` occur in the same cycle, the start edge wins: DONE=0, busy=1.
- IN writes apply byte strobes `w_strb_i`. START uses `w_strb_i[0]` only.
- IN writes while busy are dropped and answered with SLVERR.
- OUT buffer: written only by the core port. If `core_out_we_i` hits the same word as an AXI OUT read in the same cycle, the read returns the new data.
- Write path:
  - AW and W are each captured in a one-deep holding register: `aw_ready_o` = !aw_held, `w_ready_o` = !w_held.
  - When both are held and `b_valid_o`=0, the write executes, both holds clear, and `b_valid_o` rises the next cycle.
  - `b_valid_o` and `b_resp_o` stay stable until `b_ready_i`.
- Read path:
  - `ar_ready_o` = !r_valid_o.
  - On an AR handshake, `r_valid_o`, `r_data_o` and `r_resp_o` are registered the next cycle and held stable until `r_ready_i`.
- Responses: OKAY=2'b00, SLVERR=2'b10. SLVERR is returned for unmapped addresses, writes to DONE or OUT, and busy IN writes.

## Timing
- Reset values:
  - aw_ready_o=1, w_ready_o=1, ar_ready_o=1
  - b_valid_o=0, r_valid_o=0, b_resp_o=0, r_resp_o=0, r_data_o=0
  - core_start_o=0, core_in_data_o=0
  - START=0, DONE=0, busy=0, IN and OUT buffers all 0
- Read latency: 1 cycle from the AR handshake to `r_valid_o`. Back-to-back throughput is one read every 2 cycles when `r_ready_i` is held 1.
- Write latency: 1 cycle from the later of the AW/W handshakes to `b_valid_o`.
- `core_in_data_o` latency: 1 cycle after `core_in_idx_i`.
- Reset asserted mid-transaction or while busy: everything returns to reset values immediately. Holding registers and pending responses are discarded and no `core_start_o` is emitted.

## Configuration
- `IIR_REGS_ERR_RESP_EN` defined: SLVERR is generated exactly as specified under Operation.
- Not defined: every response is OKAY. Illegal writes are still dropped with no side effect, and unmapped reads still return 0.

## Test plan
- Reset, then read DONE, START and IN[5] -> each returns 0 with OKAY. `aw_ready_o`, `w_ready_o` and `ar_ready_o` are 1.
- Write IN[i]=i*4 for i=0..31, then read back IN[31] -> 0x0000007C with OKAY. A write to IN[3] with strb=4'b0001 and data 0xFFFFFFFF -> IN[3] reads 0x000000FF.
- Write START=1 then START=0 -> exactly one `core_start_o` pulse and DONE reads 0. The core writes OUT[0]=0x0000000A and OUT[31]=0xFFFFFFED, then pulses `core_done_i` -> DONE reads 1 and OUT[0]/OUT[31] read back those values.
- While busy, write IN[0]=0x1234 -> SLVERR and IN[0] unchanged (OKAY instead when `IIR_REGS_ERR_RESP_EN` is undefined). Read offset 0x300 -> data 0, SLVERR.
- Present W two cycles before AW and hold `b_ready_i`=0 for 5 cycles -> `b_valid_o` rises 1 cycle after the AW handshake, stays stable, and `aw_ready_o`/`w_ready_o` stay 0 until the B handshake.
- Pulse `core_done_i` in the same cycle as the START 0->1 write executes -> DONE=0 and busy=1. Then assert `rst_ni`=0 mid-read -> `r_valid_o`=0 and DONE=0 immediately.
